had_bkpt_evt_ctrl: RTL and testbench
====================================

// Module: had_bkpt_evt_ctrl
// PURPOSE
//  Consumes breakpoint/watchpoint hit pulses from two HAD address-match channels (A, B).
//  Applies per-channel hit counters, optional A->B chaining and external halt requests.
//  Drives the debug-mode request handshake to the core and records the debug cause.
//  Sits in HAD between the match comparators and the IU debug-entry logic.
// PARAMETERS
//  CNT_W     8   width of the per-channel hit counters and their reload values
// PORTS
//  had_clk            in   1      HAD clock; all state updates on rising edge
//  hadrst             in   1      synchronous active-high reset
//  bkpta_hit          in   1      channel A hit pulse (inst or data), one cycle per hit
//  bkptb_hit          in   1      channel B hit pulse
//  had_ext_req        in   1      external halt request level from the JTAG side
//  cfg_mbca           in   CNT_W  channel A counter reload value
//  cfg_mbcb           in   CNT_W  channel B counter reload value
//  cfg_wr_a           in   1      load cfg_mbca into cnt_a; clear chain arm
//  cfg_wr_b           in   1      load cfg_mbcb into cnt_b
//  cfg_chain          in   1      1 = B events only count once A has fired (armed)
//  cfg_sts_clr        in   2      write-1-to-clear for sticky status {b,a}
//  iu_yy_xx_dbgon     in   1      core is in debug mode (acknowledge of request)
//  had_core_dbg_mode_req out 1    debug-entry request to core
//  had_dbg_cause      out  3      cause latched at request: 0 none,1 ext,2 A,3 B,4 chain
//  had_sts_evt        out  2      sticky {B event, A event}
//  had_cnt_a          out  CNT_W  current channel A counter
//  had_cnt_b          out  CNT_W  current channel B counter
//  had_chain_armed    out  1      A has fired in chain mode, B now live
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; cnt_a=cnt_b=0; armed=0.
//  Counters (IDLE only): hit with cnt>0 -> cnt-1, no event; hit with cnt==0 -> event.
//   No wrap: counter never goes below 0. cfg_wr_x has priority over a same-cycle hit.
//  Chain (cfg_chain=1): A event sets armed, raises no request. B hit with armed=0 is
//   ignored (cnt_b frozen). B event with armed=1 -> cause 4. Armed clears on entry to
//   DBG, on cfg_wr_a, and on reset.
//  Priority in one cycle: ext > A > chain/B. Both counters still update per rules.
//  FSM:
//   IDLE: any qualifying event or had_ext_req -> REQ, latch cause, set sticky bit(s).
//   REQ : had_core_dbg_mode_req=1 (registered; event at cycle N -> req at N+1).
//         Hits ignored, counters frozen. iu_yy_xx_dbgon=1 -> DBG.
//   DBG : req=0, hits ignored. iu_yy_xx_dbgon=0 -> IDLE, cause cleared to 0.
//  Core already in debug (dbgon=1) while IDLE: events suppressed, stay IDLE.
//  Sticky: set on event; cfg_sts_clr bit clears; a same-cycle set wins over clear.
//  Reset mid-REQ/DBG: return to IDLE next edge, req drops immediately after that edge.
// STRUCTURE
//  Shared HAD package: FSM state encoding, cause codes (NONE/EXT/A/B/CHAIN).
//  One sub-module: had_bkpt_cnt (counter + reload + zero detect), instanced per channel.
// TESTING
//  mbca=0, wr_a, single A hit -> req at next cycle, cause=2, sts=01; dbgon=1 -> req=0.
//  mbca=3, wr_a, 4 A hits -> cnt_a 3,2,1,0; request on the 4th hit only.
//  chain=1, B hit, then A hit, then B hit -> first B ignored, armed=1 after A,
//   request on second B with cause=4.
//  ext_req with A hit in same cycle -> cause=1, sts_a still set.
//  hits during REQ/DBG -> counters unchanged; dbgon falls -> IDLE, cause=0.
//  hadrst asserted during REQ -> next cycle req=0, counters=0, state IDLE.

Source files
------------

// File: rtl/had_bkpt_evt_ctrl_pkg.sv
// Shared HAD definitions: debug-request FSM states, debug cause codes and
// the fixed-priority cause selector used when a request is raised.
package had_bkpt_evt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DBG  = 2'd2
  } had_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_EXT   = 3'd1,
    CAUSE_A     = 3'd2,
    CAUSE_B     = 3'd3,
    CAUSE_CHAIN = 3'd4
  } had_cause_e;

  // External request outranks channel A, which outranks channel B / chain.
  function automatic had_cause_e cause_sel(input logic ext, input logic a,
                                           input logic b, input logic chain);
    had_cause_e c;
    c = CAUSE_NONE;
    if (ext)
      c = CAUSE_EXT;
    else if (a)
      c = CAUSE_A;
    else if (b)
      c = chain ? CAUSE_CHAIN : CAUSE_B;
    return c;
  endfunction

endpackage

// File: rtl/had_bkpt_cnt.sv
// Per-channel hit counter: reload on cfg write, count down on qualified hits,
// and flag an event when a hit arrives with the counter already at zero.
module had_bkpt_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [CNT_W-1:0] reload,
  input  logic             hit,
  output logic [CNT_W-1:0] cnt,
  output logic             evt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             zero;

  assign zero = (cnt_reg == '0);
  // A reload in the same cycle swallows the hit entirely.
  assign evt  = hit & ~load & zero;
  assign cnt  = cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (load)
      cnt_next = reload;
    else if (hit && !zero)
      cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/had_bkpt_evt_ctrl.sv
// HAD breakpoint event controller: qualifies channel A/B hits and external
// halt requests, runs the debug-entry handshake and records cause/status.
module had_bkpt_evt_ctrl
  import had_bkpt_evt_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             had_clk,
  input  logic             hadrst,
  input  logic             bkpta_hit,
  input  logic             bkptb_hit,
  input  logic             had_ext_req,
  input  logic [CNT_W-1:0] cfg_mbca,
  input  logic [CNT_W-1:0] cfg_mbcb,
  input  logic             cfg_wr_a,
  input  logic             cfg_wr_b,
  input  logic             cfg_chain,
  input  logic [1:0]       cfg_sts_clr,
  input  logic             iu_yy_xx_dbgon,
  output logic             had_core_dbg_mode_req,
  output logic [2:0]       had_dbg_cause,
  output logic [1:0]       had_sts_evt,
  output logic [CNT_W-1:0] had_cnt_a,
  output logic [CNT_W-1:0] had_cnt_b,
  output logic             had_chain_armed
);

  had_state_e state_reg, state_next;
  had_cause_e cause_reg, cause_next;
  logic [1:0] sts_reg, sts_next;
  logic       armed_reg, armed_next;

  logic             live;
  logic             ext_evt;
  logic             a_req;
  logic             trig;
  logic [1:0]       load;
  logic [1:0]       hit_en;
  logic [1:0]       evt;
  logic [CNT_W-1:0] reload [2];
  logic [CNT_W-1:0] cnt    [2];

  // Hits and requests only matter while idle and the core is not already halted.
  assign live      = (state_reg == ST_IDLE) & ~iu_yy_xx_dbgon;
  assign ext_evt   = live & had_ext_req;
  assign load      = {cfg_wr_b, cfg_wr_a};
  assign reload[0] = cfg_mbca;
  assign reload[1] = cfg_mbcb;
  assign hit_en[0] = live & bkpta_hit;
  assign hit_en[1] = live & bkptb_hit & (~cfg_chain | armed_reg);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      had_bkpt_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (had_clk),
        .srst   (hadrst),
        .load   (load[gi]),
        .reload (reload[gi]),
        .hit    (hit_en[gi]),
        .cnt    (cnt[gi]),
        .evt    (evt[gi])
      );
    end
  endgenerate

  // In chain mode an A event only arms channel B; it never requests on its own.
  assign a_req = evt[0] & ~cfg_chain;
  assign trig  = ext_evt | a_req | evt[1];

  always_ff @(posedge had_clk) begin
    if (hadrst) begin
      state_reg <= ST_IDLE;
      cause_reg <= CAUSE_NONE;
      sts_reg   <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      sts_reg   <= sts_next;
      armed_reg <= armed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (trig) state_next = ST_REQ;
      ST_REQ:  if (iu_yy_xx_dbgon) state_next = ST_DBG;
      ST_DBG:  if (!iu_yy_xx_dbgon) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cause_next = cause_reg;
    if (state_reg == ST_IDLE && trig)
      cause_next = cause_sel(ext_evt, a_req, evt[1], cfg_chain);
    else if (state_reg == ST_DBG && !iu_yy_xx_dbgon)
      cause_next = CAUSE_NONE;

    // A new event in the same cycle as a clear keeps its sticky bit.
    sts_next = (sts_reg & ~cfg_sts_clr) | evt;

    armed_next = armed_reg;
    if (cfg_wr_a || (state_reg == ST_REQ && iu_yy_xx_dbgon))
      armed_next = 1'b0;
    else if (cfg_chain && evt[0])
      armed_next = 1'b1;
  end

  always_comb begin
    had_core_dbg_mode_req = (state_reg == ST_REQ);
    had_dbg_cause         = cause_reg;
    had_sts_evt           = sts_reg;
    had_cnt_a             = cnt[0];
    had_cnt_b             = cnt[1];
    had_chain_armed       = armed_reg;
  end

endmodule

// File: tb/tb_had_bkpt_evt_ctrl.sv
// Bench for had_bkpt_evt_ctrl: directed vector table, hand sequences and a
// randomized run checked against a cycle-level behavioural model.
module tb_had_bkpt_evt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       hit_a, hit_b, ext;
  logic [7:0] mbca, mbcb;
  logic       wr_a, wr_b, chain;
  logic [1:0] clr;
  logic       dbgon;
  logic       req;
  logic [2:0] cause;
  logic [1:0] sts;
  logic [7:0] cnt_a, cnt_b;
  logic       armed;

  int total = 0;
  int bad   = 0;

  // behavioural model: phase 0 idle, 1 requesting, 2 core in debug
  int m_cnt_a, m_cnt_b, m_phase, m_cause;
  bit [1:0] m_sts;
  bit m_armed;

  typedef struct {
    logic rst, a, b, ext;
    logic [7:0] mbca, mbcb;
    logic wra, wrb, ch;
    logic [1:0] clr;
    logic dbg;
    logic req;
    logic [2:0] cause;
    logic [1:0] sts;
    logic [7:0] ca, cb;
    logic arm;
  } vec_t;

  vec_t vecs[$];

  had_bkpt_evt_ctrl #(.CNT_W(8)) dut (
    .had_clk               (clk),
    .hadrst                (rst),
    .bkpta_hit             (hit_a),
    .bkptb_hit             (hit_b),
    .had_ext_req           (ext),
    .cfg_mbca              (mbca),
    .cfg_mbcb              (mbcb),
    .cfg_wr_a              (wr_a),
    .cfg_wr_b              (wr_b),
    .cfg_chain             (chain),
    .cfg_sts_clr           (clr),
    .iu_yy_xx_dbgon        (dbgon),
    .had_core_dbg_mode_req (req),
    .had_dbg_cause         (cause),
    .had_sts_evt           (sts),
    .had_cnt_a             (cnt_a),
    .had_cnt_b             (cnt_b),
    .had_chain_armed       (armed)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic addv(input logic r, a, b, e, input logic [7:0] ma, mb,
                      input logic wa, wb, ch, input logic [1:0] cl, input logic dg,
                      input logic rq, input logic [2:0] cs, input logic [1:0] st,
                      input logic [7:0] ca, cb, input logic am);
    vec_t v;
    v = '{r, a, b, e, ma, mb, wa, wb, ch, cl, dg, rq, cs, st, ca, cb, am};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, a, b, e, input logic [7:0] ma, mb,
                       input logic wa, wb, ch, input logic [1:0] cl, input logic dg);
    rst = r; hit_a = a; hit_b = b; ext = e; mbca = ma; mbcb = mb;
    wr_a = wa; wr_b = wb; chain = ch; clr = cl; dbgon = dg;
  endtask

  // Apply the rules to the values the DUT sees at this edge.
  task automatic model_step();
    int na, nb, np, nc;
    bit ea, eb, ext_ok, idle_ok, blive;
    if (rst) begin
      m_cnt_a = 0; m_cnt_b = 0; m_phase = 0; m_cause = 0; m_sts = 2'b00; m_armed = 0;
    end else begin
      idle_ok = (m_phase == 0) && !dbgon;
      na = m_cnt_a; nb = m_cnt_b; ea = 0; eb = 0;
      if (wr_a) na = int'(mbca);
      else if (idle_ok && hit_a) begin
        if (m_cnt_a > 0) na = m_cnt_a - 1; else ea = 1;
      end
      blive = !chain || m_armed;
      if (wr_b) nb = int'(mbcb);
      else if (idle_ok && hit_b && blive) begin
        if (m_cnt_b > 0) nb = m_cnt_b - 1; else eb = 1;
      end
      ext_ok = idle_ok && ext;
      np = m_phase; nc = m_cause;
      if (m_phase == 0) begin
        if (ext_ok) begin np = 1; nc = 1; end
        else if (ea && !chain) begin np = 1; nc = 2; end
        else if (eb) begin np = 1; nc = chain ? 4 : 3; end
      end else if (m_phase == 1) begin
        if (dbgon) np = 2;
      end else begin
        if (!dbgon) begin np = 0; nc = 0; end
      end
      if (wr_a || (m_phase == 1 && dbgon)) m_armed = 0;
      else if (chain && ea) m_armed = 1;
      m_sts = (m_sts & ~clr) | {eb, ea};
      m_cnt_a = na; m_cnt_b = nb; m_phase = np; m_cause = nc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [22:0] act_vec();
    return {req, cause, sts, cnt_a, cnt_b, armed};
  endfunction

  function automatic logic [22:0] model_vec();
    return {(m_phase == 1), 3'(m_cause), m_sts, 8'(m_cnt_a), 8'(m_cnt_b), m_armed};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  initial begin
    drive(1, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 2'b00, 0);

    //     rst a b e mbca mbcb wa wb ch clr  dg | rq cs  sts  ca   cb  am
    addv(1, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 1,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 1,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  1, 3'd2, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 1,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  1, 3'd2, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 1,  0, 3'd2, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b01, 1,  0, 3'd2, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd3, 8'd0, 1,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd3, 8'd0, 0);
    addv(0, 1,0,0, 8'd3, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd2, 8'd0, 0);
    addv(0, 1,0,0, 8'd3, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd1, 8'd0, 0);
    addv(0, 1,0,0, 8'd3, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 1,0,0, 8'd3, 8'd0, 0,0,0, 2'b00, 0,  1, 3'd2, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd3, 8'd0, 0,0,0, 2'b00, 1,  0, 3'd2, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd3, 8'd0, 0,0,0, 2'b11, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 1,0,0, 8'd5, 8'd0, 1,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd5, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 1,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,1,0, 8'd0, 8'd0, 0,0,1, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd1, 0,1,1, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd1, 0);
    addv(0, 0,1,0, 8'd0, 8'd1, 0,0,1, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd1, 0);
    addv(0, 1,0,0, 8'd0, 8'd1, 0,0,1, 2'b00, 0,  0, 3'd0, 2'b01, 8'd0, 8'd1, 1);
    addv(0, 0,1,0, 8'd0, 8'd1, 0,0,1, 2'b00, 0,  0, 3'd0, 2'b01, 8'd0, 8'd0, 1);
    addv(0, 0,1,0, 8'd0, 8'd1, 0,0,1, 2'b00, 0,  1, 3'd4, 2'b11, 8'd0, 8'd0, 1);
    addv(0, 0,0,0, 8'd0, 8'd1, 0,0,1, 2'b00, 1,  0, 3'd4, 2'b11, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd1, 0,0,1, 2'b11, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 1,0,1, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  1, 3'd1, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 1,  0, 3'd1, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 1,1,0, 8'd0, 8'd0, 0,0,0, 2'b00, 1,  0, 3'd1, 2'b01, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b01, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 1,0,1, 8'd0, 8'd0, 0,0,0, 2'b00, 1,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,1,0, 8'd7, 8'd0, 1,0,0, 2'b10, 0,  1, 3'd3, 2'b10, 8'd7, 8'd0, 0);
    addv(1, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);
    addv(0, 1,1,0, 8'd0, 8'd0, 0,0,0, 2'b00, 0,  1, 3'd2, 2'b11, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b00, 1,  0, 3'd2, 2'b11, 8'd0, 8'd0, 0);
    addv(0, 0,0,0, 8'd0, 8'd0, 0,0,0, 2'b11, 0,  0, 3'd0, 2'b00, 8'd0, 8'd0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].ext, vecs[i].mbca, vecs[i].mbcb,
            vecs[i].wra, vecs[i].wrb, vecs[i].ch, vecs[i].clr, vecs[i].dbg);
      tick();
      check($sformatf("vec%0d", i), 32'(act_vec()),
            32'({vecs[i].req, vecs[i].cause, vecs[i].sts, vecs[i].ca, vecs[i].cb, vecs[i].arm}));
    end

    // Request must hold for as long as the core does not acknowledge.
    drive(0, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, 2'b00, 0);
    tick();
    check("ext_req_raise", 32'({req, cause}), 32'({1'b1, 3'd1}));
    ext = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("req_hold%0d", k), 32'(req), 32'd1);
    end
    dbgon = 1;
    tick();
    check("req_ack_drop", 32'({req, cause}), 32'({1'b0, 3'd1}));
    dbgon = 0;
    tick();
    check("dbg_exit_cause", 32'(cause), 32'd0);

    // cfg_wr_a disarms the chain, so the next B hit is dead again.
    drive(0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 1, 2'b00, 0);
    tick();
    check("chain_arm", 32'({req, armed}), 32'({1'b0, 1'b1}));
    drive(0, 0, 0, 0, 8'd0, 8'd0, 1, 0, 1, 2'b11, 0);
    tick();
    check("wr_a_disarm", 32'(armed), 32'd0);
    drive(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, 1, 2'b00, 0);
    tick();
    check("b_after_disarm", 32'({req, cause, armed}), 32'd0);

    chain = 0;
    for (int n = 0; n < 1000; n++) begin
      rst   = ($urandom_range(99) == 0);
      hit_a = ($urandom_range(9) < 3);
      hit_b = ($urandom_range(9) < 3);
      ext   = ($urandom_range(19) == 0);
      wr_a  = ($urandom_range(11) == 0);
      wr_b  = ($urandom_range(11) == 0);
      mbca  = 8'($urandom_range(3));
      mbcb  = 8'($urandom_range(3));
      if ($urandom_range(49) == 0) chain = ~chain;
      clr   = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b00;
      if (m_phase == 1)      dbgon = ($urandom_range(3) == 0);
      else if (m_phase == 2) dbgon = ($urandom_range(3) != 0);
      else                   dbgon = ($urandom_range(29) == 0);
      tick();
      check($sformatf("rnd%0d", n), 32'(act_vec()), 32'(model_vec()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
